// File: rtl/jump_target_unit.sv
// ============================================================================
// Module      : jump_target_unit
// Description : ID-stage control-transfer target generator (J / branch / JR)
//               with optional delay slot and a saturating redirect counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_target_unit #(
    parameter int WORD_W     = 32,
    parameter int TARGET_W   = 26,
    parameter int IMM_W      = 16,
    parameter int SHIFT      = 2,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        mode,
    input  logic              take,
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic [TARGET_W-1:0] instr_index,
    input  logic [IMM_W-1:0]  imm,
    input  logic [WORD_W-1:0] rs_val,
    output logic              redirect,
    output logic [WORD_W-1:0] target,
    output logic              misalign,
    output logic              busy,
    output logic [CNT_W-1:0]  redirect_count
);

    localparam logic [1:0] c_MODE_J  = 2'b01;
    localparam logic [1:0] c_MODE_BR = 2'b10;
    localparam logic [1:0] c_MODE_JR = 2'b11;

    // Upper mask keeps the pc_plus4 region bits; empty when the field fills the word.
    localparam logic [WORD_W-1:0] c_UPPER_MASK =
        ~({WORD_W{1'b1}} >> (WORD_W - TARGET_W - SHIFT));
    localparam logic [WORD_W-1:0] c_ALIGN_MASK = ~({WORD_W{1'b1}} << SHIFT);
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_SLOT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [WORD_W-1:0] r_pend;
    logic [WORD_W-1:0] w_pend_n;
    logic [WORD_W-1:0] r_target;
    logic [WORD_W-1:0] w_target_n;
    logic              r_redirect;
    logic              w_redirect_n;
    logic              r_misalign;
    logic              w_misalign_n;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic [WORD_W-1:0] w_imm_ext;
    logic [WORD_W-1:0] w_j_target;
    logic [WORD_W-1:0] w_br_target;
    logic              w_jr_misaligned;

    assign w_accept        = in_valid & ~stall & ~flush;
    assign w_imm_ext       = WORD_W'($signed(imm));
    assign w_j_target      = (pc_plus4 & c_UPPER_MASK) | (WORD_W'(instr_index) << SHIFT);
    assign w_br_target     = pc_plus4 + (w_imm_ext << SHIFT);
    assign w_jr_misaligned = (rs_val & c_ALIGN_MASK) != '0;

    always_comb begin
        w_state_n    = r_state;
        w_pend_n     = r_pend;
        w_target_n   = r_target;
        w_redirect_n = 1'b0;
        w_misalign_n = 1'b0;

        if (flush) begin
            w_state_n = ST_IDLE;
            w_pend_n  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        logic              v_xfer;
                        logic [WORD_W-1:0] v_tgt;
                        v_xfer = 1'b0;
                        v_tgt  = '0;
                        case (mode)
                            c_MODE_J: begin
                                v_xfer = 1'b1;
                                v_tgt  = w_j_target;
                            end
                            c_MODE_BR: begin
                                v_xfer = take;
                                v_tgt  = w_br_target;
                            end
                            c_MODE_JR: begin
                                v_xfer       = ~w_jr_misaligned;
                                w_misalign_n = w_jr_misaligned;
                                v_tgt        = rs_val;
                            end
                            default: ;
                        endcase
                        if (v_xfer) begin
                            if (DELAY_SLOT == 0) begin
                                w_redirect_n = 1'b1;
                                w_target_n   = v_tgt;
                            end else begin
                                w_pend_n  = v_tgt;
                                w_state_n = ST_WAIT_SLOT;
                            end
                        end
                    end
                end
                ST_WAIT_SLOT: begin
                    // Any accepted instruction here is the delay slot; its own mode is dropped.
                    if (w_accept) begin
                        w_redirect_n = 1'b1;
                        w_target_n   = r_pend;
                        w_state_n    = ST_IDLE;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_target   <= '0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_pend     <= w_pend_n;
            r_target   <= w_target_n;
            r_redirect <= w_redirect_n;
            r_misalign <= w_misalign_n;
            if (w_redirect_n && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign redirect       = r_redirect;
    assign target         = r_target;
    assign misalign       = r_misalign;
    assign busy           = (r_state == ST_WAIT_SLOT);
    assign redirect_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_jump_target_unit.sv
// ============================================================================
// Module      : tb_jump_target_unit
// Description : Directed self-checking bench for jump_target_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_target_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, take;
    logic [1:0]  mode;
    logic [31:0] pc_plus4, rs_val;
    logic [25:0] instr_index;
    logic [15:0] imm;

    logic        d0_redirect, d0_misalign, d0_busy;
    logic [31:0] d0_target;
    logic [15:0] d0_count;
    logic        d1_redirect, d1_misalign, d1_busy;
    logic [31:0] d1_target;
    logic [15:0] d1_count;
    logic        c2_redirect, c2_misalign, c2_busy;
    logic [31:0] c2_target;
    logic [1:0]  c2_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jump_target_unit #(.DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .take(take), .pc_plus4(pc_plus4), .instr_index(instr_index),
        .imm(imm), .rs_val(rs_val), .redirect(d0_redirect), .target(d0_target),
        .misalign(d0_misalign), .busy(d0_busy), .redirect_count(d0_count)
    );

    jump_target_unit #(.DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .take(take), .pc_plus4(pc_plus4), .instr_index(instr_index),
        .imm(imm), .rs_val(rs_val), .redirect(d1_redirect), .target(d1_target),
        .misalign(d1_misalign), .busy(d1_busy), .redirect_count(d1_count)
    );

    jump_target_unit #(.DELAY_SLOT(0), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .take(take), .pc_plus4(pc_plus4), .instr_index(instr_index),
        .imm(imm), .rs_val(rs_val), .redirect(c2_redirect), .target(c2_target),
        .misalign(c2_misalign), .busy(c2_busy), .redirect_count(c2_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; take = 1'b0; mode = 2'b00;
        pc_plus4 = '0; rs_val = '0; instr_index = '0; imm = '0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_vec++; if ({d0_redirect, d0_misalign, d0_busy} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b expected 000", {d0_redirect, d0_misalign, d0_busy}); end
        n_vec++; if (d0_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h expected 00000000", d0_target); end
        n_vec++; if (d1_count !== 16'h0 || d1_busy !== 1'b0) begin n_err++; $display("FAIL reset_ds1: got count=%h busy=%b expected 0/0", d1_count, d1_busy); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_jump;
        apply_reset();
        in_valid = 1'b1; mode = 2'b01; pc_plus4 = 32'h4000_0010; instr_index = 26'h000_0100;
        tick();
        n_vec++; if (d0_redirect !== 1'b1) begin n_err++; $display("FAIL j_redirect: got %b expected 1", d0_redirect); end
        n_vec++; if (d0_target !== 32'h4000_0400) begin n_err++; $display("FAIL j_target: got %h expected 40000400", d0_target); end
        n_vec++; if (d0_count !== 16'd1) begin n_err++; $display("FAIL j_count: got %0d expected 1", d0_count); end
        idle_inputs();
        tick();
        n_vec++; if (d0_redirect !== 1'b0 || d0_target !== 32'h4000_0400) begin n_err++; $display("FAIL j_hold: got redirect=%b target=%h expected 0/40000400", d0_redirect, d0_target); end
    endtask

    task automatic test_branch;
        in_valid = 1'b1; mode = 2'b10; take = 1'b1; pc_plus4 = 32'h0000_1000; imm = 16'hFFFE;
        tick();
        n_vec++; if (d0_redirect !== 1'b1 || d0_target !== 32'h0000_0FF8) begin n_err++; $display("FAIL br_back: got redirect=%b target=%h expected 1/00000ff8", d0_redirect, d0_target); end
        n_vec++; if (d0_count !== 16'd2) begin n_err++; $display("FAIL br_count: got %0d expected 2", d0_count); end
        take = 1'b0; pc_plus4 = 32'h0000_5000; imm = 16'h0004;
        tick();
        n_vec++; if (d0_redirect !== 1'b0 || d0_target !== 32'h0000_0FF8) begin n_err++; $display("FAIL br_untaken: got redirect=%b target=%h expected 0/00000ff8", d0_redirect, d0_target); end
        take = 1'b1; pc_plus4 = 32'hFFFF_FFFC; imm = 16'h0001;
        tick();
        n_vec++; if (d0_redirect !== 1'b1 || d0_target !== 32'h0000_0000) begin n_err++; $display("FAIL br_wrap: got redirect=%b target=%h expected 1/00000000", d0_redirect, d0_target); end
        idle_inputs();
        tick();
    endtask

    task automatic test_jr;
        in_valid = 1'b1; mode = 2'b11; rs_val = 32'h0000_2002;
        tick();
        n_vec++; if (d0_misalign !== 1'b1 || d0_redirect !== 1'b0) begin n_err++; $display("FAIL jr_misalign: got misalign=%b redirect=%b expected 1/0", d0_misalign, d0_redirect); end
        n_vec++; if (d0_count !== 16'd3) begin n_err++; $display("FAIL jr_mis_count: got %0d expected 3", d0_count); end
        rs_val = 32'h0000_2000;
        tick();
        n_vec++; if (d0_redirect !== 1'b1 || d0_misalign !== 1'b0 || d0_target !== 32'h0000_2000) begin n_err++; $display("FAIL jr_ok: got redirect=%b misalign=%b target=%h expected 1/0/00002000", d0_redirect, d0_misalign, d0_target); end
        idle_inputs();
        tick();
        n_vec++; if (d0_redirect !== 1'b0 || d0_count !== 16'd4) begin n_err++; $display("FAIL jr_after: got redirect=%b count=%0d expected 0/4", d0_redirect, d0_count); end
        // Flush outranks an otherwise accepted jump.
        in_valid = 1'b1; mode = 2'b01; flush = 1'b1; instr_index = 26'h0000_0040;
        tick();
        n_vec++; if (d0_redirect !== 1'b0 || d0_target !== 32'h0000_2000) begin n_err++; $display("FAIL flush_j: got redirect=%b target=%h expected 0/00002000", d0_redirect, d0_target); end
        idle_inputs();
        tick();
    endtask

    task automatic test_delay_slot;
        apply_reset();
        in_valid = 1'b1; mode = 2'b10; take = 1'b1; pc_plus4 = 32'h0000_1000; imm = 16'h0010;
        tick();
        n_vec++; if (d1_busy !== 1'b1 || d1_redirect !== 1'b0) begin n_err++; $display("FAIL ds_accept: got busy=%b redirect=%b expected 1/0", d1_busy, d1_redirect); end
        mode = 2'b00; take = 1'b0; pc_plus4 = 32'h0000_1004; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (d1_redirect !== 1'b0 || d1_busy !== 1'b1) begin n_err++; $display("FAIL ds_stall%0d: got redirect=%b busy=%b expected 0/1", i, d1_redirect, d1_busy); end
        end
        stall = 1'b0;
        tick();
        n_vec++; if (d1_redirect !== 1'b1 || d1_target !== 32'h0000_1040 || d1_busy !== 1'b0) begin n_err++; $display("FAIL ds_release: got redirect=%b target=%h busy=%b expected 1/00001040/0", d1_redirect, d1_target, d1_busy); end
        n_vec++; if (d1_count !== 16'd1) begin n_err++; $display("FAIL ds_count: got %0d expected 1", d1_count); end
        idle_inputs();
        tick();
        n_vec++; if (d1_redirect !== 1'b0) begin n_err++; $display("FAIL ds_pulse_end: got %b expected 0", d1_redirect); end
    endtask

    task automatic test_flush_reset;
        in_valid = 1'b1; mode = 2'b10; take = 1'b1; pc_plus4 = 32'h0000_2000; imm = 16'h0004;
        tick();
        n_vec++; if (d1_busy !== 1'b1) begin n_err++; $display("FAIL fl_busy: got %b expected 1", d1_busy); end
        flush = 1'b1; mode = 2'b00; take = 1'b0;
        tick();
        n_vec++; if (d1_busy !== 1'b0 || d1_redirect !== 1'b0) begin n_err++; $display("FAIL fl_flush: got busy=%b redirect=%b expected 0/0", d1_busy, d1_redirect); end
        flush = 1'b0;
        tick();
        n_vec++; if (d1_redirect !== 1'b0 || d1_target !== 32'h0000_1040) begin n_err++; $display("FAIL fl_no_redirect: got redirect=%b target=%h expected 0/00001040", d1_redirect, d1_target); end
        idle_inputs();
        tick();
        n_vec++; if (d1_redirect !== 1'b0 || d1_count !== 16'd1) begin n_err++; $display("FAIL fl_count: got redirect=%b count=%0d expected 0/1", d1_redirect, d1_count); end
        in_valid = 1'b1; mode = 2'b10; take = 1'b1; pc_plus4 = 32'h0000_3000; imm = 16'h0008;
        tick();
        idle_inputs();
        n_vec++; if (d1_busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b expected 1", d1_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if ({d1_busy, d1_redirect, d1_misalign} !== 3'b000 || d1_target !== 32'h0 || d1_count !== 16'h0) begin n_err++; $display("FAIL rst_async: got busy=%b target=%h count=%0d expected 0/0/0", d1_busy, d1_target, d1_count); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0]  exp_cnt;
        logic [31:0] exp_tgt;
        apply_reset();
        in_valid = 1'b1; mode = 2'b01; pc_plus4 = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            instr_index = 26'(i + 1);
            tick();
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            exp_tgt = 32'h8000_0000 | 32'((i + 1) * 4);
            n_vec++; if (c2_redirect !== 1'b1 || c2_target !== exp_tgt || c2_count !== exp_cnt) begin n_err++; $display("FAIL b2b_%0d: got redirect=%b target=%h count=%0d expected 1/%h/%0d", i, c2_redirect, c2_target, c2_count, exp_tgt, exp_cnt); end
        end
        idle_inputs();
        tick();
        n_vec++; if (c2_redirect !== 1'b0 || c2_count !== 2'd3) begin n_err++; $display("FAIL b2b_end: got redirect=%b count=%0d expected 0/3", c2_redirect, c2_count); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_jump();
        test_branch();
        test_jr();
        test_delay_slot();
        test_flush_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
